// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Optional rotate support is selected with SHIFT_PIPE_ROTATE_EN (see shift_stage).
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_t;

    function automatic int shamt_w(input int width);
        return $clog2(width);
    endfunction

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_TAG_W   = 5;
    localparam int DEF_SHAMT_W = shamt_w(DEF_WIDTH);

    // Bank layout at the default configuration; shift_pipe re-declares it with its own widths.
    typedef struct packed {
        logic                   vld;
        logic [DEF_WIDTH-1:0]   data;
        logic [DEF_SHAMT_W-1:0] shamt;
        shift_op_t              op;
        logic [DEF_TAG_W-1:0]   tag;
        logic                   sign;
    } shift_bank_t;

endpackage

// File: rtl/shift_stage.sv
// One combinational shifter stage: shifts by DIST when enabled.
// The rotate wrap path exists only when SHIFT_PIPE_ROTATE_EN is defined.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic             enable,
    input  shift_op_t        op,
    input  logic             sign,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] shifted
);

    always_comb begin
        shifted = data;
        if (enable) begin
            case (op)
                SHIFT_SLL: shifted = data << DIST;
                SHIFT_SRL: shifted = data >> DIST;
                // sign is the operand MSB captured at input, so every stage fills consistently
                SHIFT_SRA: shifted = {{DIST{sign}}, data[WIDTH-1:DIST]};
`ifdef SHIFT_PIPE_ROTATE_EN
                SHIFT_ROR: shifted = {data[DIST-1:0], data[WIDTH-1:DIST]};
`endif
                default:   shifted = data;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter with valid/ready on both sides and a pass-through tag.
// Rotate (op 11) is built only when SHIFT_PIPE_ROTATE_EN is defined; otherwise op 11 passes data through.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int PIPE_EVERY = 2,
    parameter int TAG_W      = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_op,
    input  logic [shamt_w(WIDTH)-1:0]  in_shamt,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [TAG_W-1:0]           out_tag
);

    localparam int S = shamt_w(WIDTH);
    localparam int B = (S + PIPE_EVERY - 1) / PIPE_EVERY;

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] data;
        logic [S-1:0]     shamt;
        shift_op_t        op;
        logic [TAG_W-1:0] tag;
        logic             sign;
    } bank_t;

    bank_t            src      [B];   // what feeds each bank's stage group
    bank_t            nxt      [B];
    bank_t            bank_q   [B];
    logic [WIDTH-1:0] stage_out[S];
    logic [WIDTH-1:0] grp_out  [B];
    logic [B-1:0]     adv;

    // A bank advances if it, or any bank downstream of it, is empty, or the consumer accepts.
    always_comb begin
        logic chain;
        chain = out_ready;
        for (int b = B - 1; b >= 0; b--) begin
            chain  = chain || !bank_q[b].vld;
            adv[b] = chain;
        end
    end

    assign in_ready = !reset && !flush && adv[0];

    always_comb begin
        src[0].vld   = in_valid && in_ready;
        src[0].data  = in_data;
        src[0].shamt = in_shamt;
        src[0].op    = shift_op_t'(in_op);
        src[0].tag   = in_tag;
        src[0].sign  = in_data[WIDTH-1];
        for (int b = 1; b < B; b++) src[b] = bank_q[b-1];
    end

    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int G = k / PIPE_EVERY;
        logic [WIDTH-1:0] din;
        if (k % PIPE_EVERY == 0) begin : g_head
            assign din = src[G].data;
        end else begin : g_body
            assign din = stage_out[k-1];
        end
        shift_stage #(.WIDTH(WIDTH), .DIST(1 << k)) u_stage (
            .enable  (src[G].shamt[k]),
            .op      (src[G].op),
            .sign    (src[G].sign),
            .data    (din),
            .shifted (stage_out[k])
        );
    end

    for (genvar b = 0; b < B; b++) begin : g_grp
        localparam int L = ((b + 1) * PIPE_EVERY > S) ? S - 1 : (b + 1) * PIPE_EVERY - 1;
        assign grp_out[b] = stage_out[L];
    end

    always_comb begin
        for (int b = 0; b < B; b++) begin
            nxt[b]      = src[b];
            nxt[b].data = grp_out[b];
        end
    end

    // Data fields load only with a valid operation, so bubbles and flushes leave them untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < B; b++) bank_q[b] <= '0;
        end else begin
            for (int b = 0; b < B; b++) begin
                if (flush)
                    bank_q[b].vld <= 1'b0;
                else if (adv[b]) begin
                    if (src[b].vld) bank_q[b] <= nxt[b];
                    else            bank_q[b].vld <= 1'b0;
                end
            end
        end
    end

    assign out_valid = bank_q[B-1].vld;
    assign out_data  = bank_q[B-1].data;
    assign out_tag   = bank_q[B-1].tag;

endmodule
